// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   - op encodings driven on muldiv_unit.op
//   - FSM state enum
//   - counter width helpers
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = $clog2(WIDTH_DEF);

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Counter width for a given iteration count (never below one bit).
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  // True for DIVU/DIV.
  function automatic logic is_div_op(input logic [1:0] o);
    return (o == OP_DIVU) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration of the multiply/divide datapath (purely
// combinational).
//   acc_in   : 2*WIDTH accumulator {upper, lower}
//   operand  : multiplicand (multiply) or divisor (divide), magnitude only
//   is_div   : 1 = restoring divide step, 0 = shift-add multiply step
//   acc_out  : accumulator after this iteration
//   q_bit    : quotient bit produced by a divide step (0 for multiply)
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_out,
  output logic               q_bit
);

  logic [WIDTH:0]   add_sum_s;
  logic [2*WIDTH:0] shifted_s;
  logic [WIDTH+1:0] diff_s;

  // Single iteration: shift-add for multiply, shift/trial-subtract for divide.
  always_comb begin
    // Multiply: conditional add into the upper half keeps the carry in bit WIDTH,
    // which becomes the new MSB after the right shift.
    add_sum_s = {1'b0, acc_in[2*WIDTH-1:WIDTH]}
              + (acc_in[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    // Divide: upper WIDTH+1 bits of the left-shifted accumulator hold the
    // partial remainder including the bit shifted out of the top.
    shifted_s = {acc_in, 1'b0};
    diff_s    = {1'b0, shifted_s[2*WIDTH:WIDTH]} - {2'b00, operand};
    if (is_div) begin
      q_bit = ~diff_s[WIDTH+1];
      if (q_bit) begin
        acc_out = {diff_s[WIDTH-1:0], shifted_s[WIDTH-1:1], 1'b1};
      end else begin
        acc_out = shifted_s[2*WIDTH-1:0];
      end
    end else begin
      q_bit   = 1'b0;
      acc_out = {add_sum_s, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU unit holding HI/LO.
//   clk, rst_n         : clock, asynchronous active-low reset
//   start, op          : issue request (sampled in IDLE) and operation select
//   rs_val, rt_val     : multiplicand/dividend, multiplier/divisor
//   mthi, mtlo, wdata  : direct HI/LO writes, honoured in IDLE without start
//   busy               : operation in progress
//   done, div_by_zero  : one-cycle result pulse and divide-by-zero flag
//   hi, lo             : HI/LO architectural registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cnt_width(WIDTH);

  state_t             state_r, state_nxt_s;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   rs_r;
  logic [WIDTH-1:0]   opnd_r;
  logic [2*WIDTH-1:0] acc_r, acc_step_s;
  logic [CW-1:0]      cnt_r;
  logic               neg_rs_r, neg_rt_r;
  logic               q_bit_s;

  logic               neg_rs_s, neg_rt_s;
  logic [WIDTH-1:0]   abs_rs_s, abs_rt_s;
  logic               div_zero_s;
  logic [2*WIDTH-1:0] mult_res_s;

  logic               busy_r, done_r, dbz_r;
  logic [WIDTH-1:0]   hi_r, lo_r;
  logic               busy_nxt_s, done_nxt_s, dbz_nxt_s;
  logic [WIDTH-1:0]   hi_nxt_s, lo_nxt_s;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_in  (acc_r),
    .operand (opnd_r),
    .is_div  (is_div_op(op_r)),
    .acc_out (acc_step_s),
    .q_bit   (q_bit_s)
  );

  // Operand sign capture and magnitudes (signed ops only).
  always_comb begin
    neg_rs_s   = op[0] & rs_val[WIDTH-1];
    neg_rt_s   = op[0] & rt_val[WIDTH-1];
    abs_rs_s   = neg_rs_s ? -rs_val : rs_val;
    abs_rt_s   = neg_rt_s ? -rt_val : rt_val;
    div_zero_s = (opnd_r == {WIDTH{1'b0}});
    mult_res_s = (neg_rs_r ^ neg_rt_r) ? -acc_r : acc_r;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = CALC;
        else       state_nxt_s = IDLE;
      end
      CALC: begin
        if (cnt_r == CW'(WIDTH - 1)) state_nxt_s = FIX;
        else                         state_nxt_s = CALC;
      end
      FIX:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output logic: next values for the registered outputs and HI/LO.
  always_comb begin
    hi_nxt_s   = hi_r;
    lo_nxt_s   = lo_r;
    done_nxt_s = 1'b0;
    dbz_nxt_s  = 1'b0;
    busy_nxt_s = (state_nxt_s != IDLE);
    case (state_r)
      IDLE: begin
        // start takes priority; mthi/mtlo only act on an idle, non-issuing cycle.
        if (!start) begin
          if (mthi) hi_nxt_s = wdata;
          else      hi_nxt_s = hi_r;
          if (mtlo) lo_nxt_s = wdata;
          else      lo_nxt_s = lo_r;
        end else begin
          hi_nxt_s = hi_r;
          lo_nxt_s = lo_r;
        end
      end
      CALC: begin
        hi_nxt_s = hi_r;
        lo_nxt_s = lo_r;
      end
      FIX: begin
        done_nxt_s = 1'b1;
        if (is_div_op(op_r)) begin
          if (div_zero_s) begin
            // Raw dividend (not its magnitude) and all-ones quotient, no sign fix.
            dbz_nxt_s = 1'b1;
            hi_nxt_s  = rs_r;
            lo_nxt_s  = {WIDTH{1'b1}};
          end else begin
            lo_nxt_s = (neg_rs_r ^ neg_rt_r) ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
            hi_nxt_s = neg_rs_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
          end
        end else begin
          hi_nxt_s = mult_res_s[2*WIDTH-1:WIDTH];
          lo_nxt_s = mult_res_s[WIDTH-1:0];
        end
      end
      default: begin
        hi_nxt_s = hi_r;
        lo_nxt_s = lo_r;
      end
    endcase
  end

  // Registered outputs and HI/LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      hi_r   <= {WIDTH{1'b0}};
      lo_r   <= {WIDTH{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
      dbz_r  <= dbz_nxt_s;
      hi_r   <= hi_nxt_s;
      lo_r   <= lo_nxt_s;
    end
  end

  // Operand latch, accumulator and iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r     <= 2'b00;
      rs_r     <= {WIDTH{1'b0}};
      opnd_r   <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      cnt_r    <= {CW{1'b0}};
      neg_rs_r <= 1'b0;
      neg_rt_r <= 1'b0;
    end else if (state_r == IDLE && start) begin
      op_r     <= op;
      rs_r     <= rs_val;
      neg_rs_r <= neg_rs_s;
      neg_rt_r <= neg_rt_s;
      cnt_r    <= {CW{1'b0}};
      // Lower half seeds the multiplier or dividend; upper half starts cleared.
      if (is_div_op(op)) begin
        opnd_r <= abs_rt_s;
        acc_r  <= {{WIDTH{1'b0}}, abs_rs_s};
      end else begin
        opnd_r <= abs_rs_s;
        acc_r  <= {{WIDTH{1'b0}}, abs_rt_s};
      end
    end else if (state_r == CALC) begin
      acc_r <= acc_step_s;
      cnt_r <= cnt_r + CW'(1);
    end else begin
      acc_r <= acc_r;
      cnt_r <= cnt_r;
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dbz_r;
  assign hi          = hi_r;
  assign lo          = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        mthi, mtlo;
  logic [31:0] wdata;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .mthi(mthi), .mtlo(mtlo),
    .wdata(wdata), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation (caller sits 1 time unit after a rising edge) and wait
  // for done. lat counts edges with the start-sampling edge as 1; 0 = timeout.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output bit busy_ok, output logic dbz_done,
                        output bit dbz_early);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; busy_ok = 1'b1; dbz_done = 1'b0; dbz_early = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (done === 1'b1) begin
        lat = c;
        dbz_done = div_by_zero;
        if (busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (div_by_zero !== 1'b0) dbz_early = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 2'b00; rs_val = 32'd0; rt_val = 32'd0;
    mthi = 1'b0; mtlo = 1'b0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({busy, done, div_by_zero} !== 3'b000 || hi !== 32'd0 || lo !== 32'd0) begin
      fails++;
      $display("FAIL reset_state: busy/done/dbz=%b%b%b hi=%h lo=%h, required 000 hi=0 lo=0",
               busy, done, div_by_zero, hi, lo);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_multu();
    int lat; bit bok; logic dz; bit dze;
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bok, dz, dze);
    tests++;
    if (lat !== 34) begin fails++; $display("FAIL multu_latency: got %0d, required 34", lat); end
    tests++;
    if (!bok) begin fails++; $display("FAIL multu_busy: busy not high throughout or high with done, required 1 then 0"); end
    tests++;
    if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      fails++; $display("FAIL multu_result: hi=%h lo=%h, required fffffffe 00000001", hi, lo);
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL multu_done_pulse: done=%b a cycle later, required 0", done); end
  endtask

  task automatic test_mult_div();
    int lat; bit bok; logic dz; bit dze;
    run_op(2'b01, 32'hFFFFFFFD, 32'd7, lat, bok, dz, dze);
    tests++;
    if (lat !== 34 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
      fails++; $display("FAIL mult_signed: lat=%0d hi=%h lo=%h, required 34 ffffffff ffffffeb", lat, hi, lo);
    end
    @(posedge clk); #1;
    run_op(2'b11, 32'hFFFFFFF9, 32'd2, lat, bok, dz, dze);
    tests++;
    if (lat !== 34 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD || dz !== 1'b0) begin
      fails++; $display("FAIL div_signed: lat=%0d hi=%h lo=%h dbz=%b, required 34 ffffffff fffffffd 0",
                        lat, hi, lo, dz);
    end
  endtask

  task automatic test_div_zero();
    int lat; bit bok; logic dz; bit dze;
    @(posedge clk); #1;
    run_op(2'b10, 32'd100, 32'd0, lat, bok, dz, dze);
    tests++;
    if (lat !== 34 || hi !== 32'h00000064 || lo !== 32'hFFFFFFFF) begin
      fails++; $display("FAIL divu_zero_result: lat=%0d hi=%h lo=%h, required 34 00000064 ffffffff", lat, hi, lo);
    end
    tests++;
    if (dz !== 1'b1 || dze) begin
      fails++; $display("FAIL divu_zero_flag: at_done=%b early=%0d, required 1 and 0", dz, dze);
    end
    @(posedge clk); #1;
    tests++;
    if (div_by_zero !== 1'b0) begin fails++; $display("FAIL divu_zero_flag_after: got %b, required 0", div_by_zero); end
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, lat, bok, dz, dze);
    tests++;
    if (lat !== 34 || hi !== 32'd0 || lo !== 32'h80000000 || dz !== 1'b0) begin
      fails++; $display("FAIL div_overflow: lat=%0d hi=%h lo=%h dbz=%b, required 34 00000000 80000000 0",
                        lat, hi, lo, dz);
    end
  endtask

  task automatic test_back_to_back();
    int ndone; int first_done; logic [31:0] h1, l1; bit held_ok;
    int lat; bit bok; logic dz; bit dze;
    @(posedge clk); #1;
    // DIVU 9/4 with a stray MULTU 2*2 start pulsed while busy.
    start = 1'b1; op = 2'b10; rs_val = 32'd9; rt_val = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; first_done = 0; h1 = 32'd0; l1 = 32'd0; held_ok = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      if (c == 10) begin
        start = 1'b1; op = 2'b00; rs_val = 32'd2; rt_val = 32'd2;
        if (hi !== 32'd0 || lo !== 32'h80000000) held_ok = 1'b0;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin first_done = c; h1 = hi; l1 = lo; end
      end
      if (ndone == 0 && (hi !== 32'd0 || lo !== 32'h80000000)) held_ok = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    tests++;
    if (ndone !== 1 || first_done !== 34) begin
      fails++; $display("FAIL busy_start_ignored: dones=%0d first_at=%0d, required 1 at 34", ndone, first_done);
    end
    tests++;
    if (h1 !== 32'd1 || l1 !== 32'd2) begin
      fails++; $display("FAIL divu_9_4: hi=%h lo=%h, required 00000001 00000002", h1, l1);
    end
    tests++;
    if (!held_ok) begin fails++; $display("FAIL hilo_held_calc: hi/lo changed before done, required 00000000 80000000"); end
    // Start issued in the done cycle.
    run_op(2'b10, 32'd20, 32'd6, lat, bok, dz, dze);
    tests++;
    if (lat !== 34 || hi !== 32'd2 || lo !== 32'd3) begin
      fails++; $display("FAIL divu_20_6: lat=%0d hi=%h lo=%h, required 34 00000002 00000003", lat, hi, lo);
    end
    run_op(2'b00, 32'd5, 32'd3, lat, bok, dz, dze);
    tests++;
    if (lat !== 34 || hi !== 32'd0 || lo !== 32'd15) begin
      fails++; $display("FAIL start_in_done_cycle: lat=%0d hi=%h lo=%h, required 34 00000000 0000000f", lat, hi, lo);
    end
  endtask

  task automatic test_mthi_mtlo();
    bit seen;
    @(posedge clk); #1;
    mthi = 1'b1; wdata = 32'h00001234;
    @(posedge clk); #1;
    mthi = 1'b0;
    tests++;
    if (hi !== 32'h00001234 || lo !== 32'd15) begin
      fails++; $display("FAIL mthi_write: hi=%h lo=%h, required 00001234 0000000f", hi, lo);
    end
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000ABCD;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    tests++;
    if (hi !== 32'h0000ABCD || lo !== 32'h0000ABCD) begin
      fails++; $display("FAIL mthi_mtlo_both: hi=%h lo=%h, required 0000abcd 0000abcd", hi, lo);
    end
    // mtlo with start, then held during busy: every write must be dropped.
    start = 1'b1; op = 2'b00; rs_val = 32'd4; rt_val = 32'd5; mtlo = 1'b1; wdata = 32'h0000DEAD;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if (lo !== 32'h0000ABCD || busy !== 1'b1) begin
      fails++; $display("FAIL mtlo_dropped: lo=%h busy=%b, required 0000abcd 1", lo, busy);
    end
    mtlo = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    tests++;
    if (!seen || hi !== 32'd0 || lo !== 32'd20) begin
      fails++; $display("FAIL mtlo_start_op: done=%0d hi=%h lo=%h, required 1 00000000 00000014", seen, hi, lo);
    end
  endtask

  task automatic test_reset_abort();
    int ndone; int lat; bit bok; logic dz; bit dze;
    @(posedge clk); #1;
    start = 1'b1; op = 2'b00; rs_val = 32'hFFFFFFFF; rt_val = 32'hFFFFFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL reset_abort_state: hi=%h lo=%h busy=%b done=%b, required 0 0 0 0", hi, lo, busy, done);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) ndone++;
    end
    tests++;
    if (ndone !== 0) begin fails++; $display("FAIL reset_abort_no_done: %0d active cycles, required 0", ndone); end
    run_op(2'b00, 32'd6, 32'd7, lat, bok, dz, dze);
    tests++;
    if (lat !== 34 || hi !== 32'd0 || lo !== 32'd42) begin
      fails++; $display("FAIL post_reset_multu: lat=%0d hi=%h lo=%h, required 34 00000000 0000002a", lat, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult_div();
    test_div_zero();
    test_back_to_back();
    test_mthi_mtlo();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
